board_clkgen_blink: RTL and testbench
=====================================

// Module: board_clkgen_blink
// PURPOSE
//   Board-level clock/heartbeat generator that sits in the FPGA top wrapper, between the board oscillator and the SoC.
//   - Runtime-programmable divider: 50%-duty derived clock (usr_clk_o) plus a one-cycle enable pulse (usr_clk_en_o).
//   - CH independent PWM/blink channels for LEDs, each with its own period and duty.
//   - All reconfiguration is shadowed and applied only at period boundaries: no runt pulses, no glitches.
// PARAMETERS
//   DIV_W          8           width of divider half-period value
//   DIV_DEFAULT    5           reset half-period in clk cycles (clk/10)
//   CH             4           number of blink channels
//   PER_W          26          width of blink period/duty counters
//   PERIOD_DEFAULT 50_000_000  reset blink period in clk cycles, all channels
//   DUTY_DEFAULT   25_000_000  reset blink high time in clk cycles, all channels
// PORTS
//   clk             in   1         board clock; the only clock
//   rst             in   1         synchronous, active-high reset
//   div_half_i      in   DIV_W     new divider half-period (0 treated as 1)
//   div_load_i      in   1         strobe: capture div_half_i into shadow
//   usr_clk_o       out  1         divided clock, registered
//   usr_clk_en_o    out  1         1-cycle pulse in the clk cycle where usr_clk_o goes 0->1
//   blink_period_i  in   CH*PER_W  per-channel period, ch k at [k*PER_W +: PER_W]
//   blink_duty_i    in   CH*PER_W  per-channel high time, same packing
//   blink_load_i    in   CH        per-channel strobe: capture period/duty into shadow
//   blink_o         out  CH        registered blink outputs
//   blink_wrap_o    out  CH        1-cycle pulse when a channel's counter wraps to 0
// BEHAVIOUR
//   Reset:
//   - usr_clk_o=0, usr_clk_en_o=0, blink_o=0, blink_wrap_o=0, all counters=0.
//   - Active divider and shadow = DIV_DEFAULT; active and shadow period/duty = *_DEFAULT.
//   - Pending flags cleared. Reset mid-operation aborts the current period immediately.
//   Divider:
//   - div_cnt counts 0..half-1. At half-1, usr_clk_o toggles and div_cnt returns to 0.
//   - usr_clk_en_o is asserted in the same cycle as the 0->1 toggle of usr_clk_o.
//   - Full period = 2*half clk cycles.
//   - div_load_i sets a pending flag and overwrites the shadow. A later load before apply replaces it (last wins).
//   - The pending shadow becomes active at the terminal count where usr_clk_o toggles 1->0.
//     Each new period therefore starts with a complete low phase of the new length.
//   - Load in the same cycle as that terminal count: the old value applies to the boundary; the new value waits for the next one.
//   - half=1 gives usr_clk_o = clk/2 and usr_clk_en_o asserted every other cycle.
//   Blink channel k (independent of the divider):
//   - cnt counts 0..period-1 and wraps. blink_wrap_o[k]=1 in the cycle cnt goes period-1 -> 0.
//   - blink_o[k] is registered: (cnt_next < duty). This gives exactly duty high cycles per period, starting at cnt=0.
//   - duty=0 gives constant 0. duty>=period gives constant 1.
//   - period=0: channel disabled; cnt held at 0, blink_o=0, no wrap pulses. A pending shadow is applied immediately.
//   - Shadow/apply works as for the divider: a pending value applies at the wrap. A load in the wrap cycle waits one further period.
//   Arithmetic:
//   - All comparisons unsigned, full width. There is no overflow path; counters never exceed active period-1.
// CONFIGURATION
//   BLINK_SYNC_EN defined:
//   - Adds input blink_sync_i (1 bit).
//   - A pulse forces every channel cnt to 0 on the next cycle and applies all pending shadows at once.
//   - No blink_wrap_o pulse is generated for the forced restart.
//   - If it coincides with a load, the new load stays pending.
//   BLINK_SYNC_EN undefined: the port is absent and channels run free-phase.
// STRUCTURE
//   - Package board_clkgen_pkg: DIV_DEFAULT, PERIOD_DEFAULT, DUTY_DEFAULT constants; typedef blink_cfg_t {period, duty}.
//   - Sub-module blink_channel: one channel (counter, shadow, pending, output register). Instantiated CH times in a generate loop.
//   - The divider stays inline in the top.
// TESTING
//   1. Reset, defaults with DIV_DEFAULT=5 -> usr_clk_o period 10 clk (5 low/5 high); usr_clk_en_o one pulse every 10 clk, aligned to the rising edge.
//   2. div_half_i=2 loaded while usr_clk_o high -> remaining high phase keeps the old length, then exact 4-clk periods; no phase shorter than 2 clk.
//   3. Channel 0 period=10, duty=3 -> blink_o[0] high 3 / low 7 repeating; blink_wrap_o[0] every 10 clk.
//   4. Channel 1 duty=0, channel 2 duty=12 with period=10, channel 3 period=0 -> 0 / constant 1 / 0; channel 3 shows no wraps.
//   5. Reload channel 0 to period=6, duty=6 in its wrap cycle -> one further old period of 10, then constant high.
//   6. rst pulsed mid-period -> all outputs 0 next cycle; defaults restored. With BLINK_SYNC_EN: blink_sync_i realigns all channels to cnt=0 on the same cycle.

Source files
------------

// File: rtl/board_clkgen_pkg.sv
// rtl/board_clkgen_pkg.sv - shared constants and blink channel config type for the board clock/heartbeat generator
package board_clkgen_pkg;

    localparam int DIV_W          = 8;
    localparam int PER_W          = 26;
    localparam int DIV_DEFAULT    = 5;
    localparam int PERIOD_DEFAULT = 50_000_000;
    localparam int DUTY_DEFAULT   = 25_000_000;

    typedef struct packed {
        logic [PER_W-1:0] period;
        logic [PER_W-1:0] duty;
    } blink_cfg_t;

endpackage

// File: rtl/board_clkgen_blink_channel.sv
// rtl/board_clkgen_blink_channel.sv - one PWM/blink channel with shadowed period/duty applied at wrap
module blink_channel
    import board_clkgen_pkg::*;
#(
    parameter int PERIOD_RST = 50_000_000,
    parameter int DUTY_RST   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] period_i,
    input  logic [PER_W-1:0] duty_i,
    input  logic             load_i,
    input  logic             sync_i,
    output logic             blink_o,
    output logic             wrap_o
);

    localparam blink_cfg_t CFG_RST = '{period: PER_W'(PERIOD_RST), duty: PER_W'(DUTY_RST)};

    blink_cfg_t       act;
    blink_cfg_t       shadow;
    blink_cfg_t       act_nx;
    logic             pend;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] cnt_nx;
    logic             disabled;
    logic             at_wrap;
    logic             apply;

    // A disabled channel sits at cnt=0, so any pending shadow takes effect immediately.
    always_comb begin
        disabled = (act.period == '0);
        at_wrap  = !disabled && (cnt == act.period - PER_W'(1));
        apply    = pend && (disabled || at_wrap || sync_i);
        act_nx   = apply ? shadow : act;
        cnt_nx   = (disabled || at_wrap || sync_i) ? '0 : cnt + PER_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act     <= CFG_RST;
            shadow  <= CFG_RST;
            pend    <= 1'b0;
            cnt     <= '0;
            blink_o <= 1'b0;
            wrap_o  <= 1'b0;
        end else begin
            act     <= act_nx;
            cnt     <= cnt_nx;
            blink_o <= (act_nx.period != '0) && (cnt_nx < act_nx.duty);
            wrap_o  <= at_wrap && !sync_i;
            // A load landing on the apply cycle stays pending for the next boundary.
            if (load_i) begin
                shadow <= '{period: period_i, duty: duty_i};
                pend   <= 1'b1;
            end else if (apply) begin
                pend   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_clkgen_blink.sv
// rtl/board_clkgen_blink.sv - divided user clock plus CH blink channels; BLINK_SYNC_EN adds blink_sync_i
module board_clkgen_blink #(
    parameter int DIV_W          = board_clkgen_pkg::DIV_W,
    parameter int DIV_DEFAULT    = board_clkgen_pkg::DIV_DEFAULT,
    parameter int CH             = 4,
    parameter int PER_W          = board_clkgen_pkg::PER_W,
    parameter int PERIOD_DEFAULT = board_clkgen_pkg::PERIOD_DEFAULT,
    parameter int DUTY_DEFAULT   = board_clkgen_pkg::DUTY_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    div_half_i,
    input  logic                div_load_i,
    output logic                usr_clk_o,
    output logic                usr_clk_en_o,
    input  logic [CH*PER_W-1:0] blink_period_i,
    input  logic [CH*PER_W-1:0] blink_duty_i,
    input  logic [CH-1:0]       blink_load_i,
`ifdef BLINK_SYNC_EN
    input  logic                blink_sync_i,
`endif
    output logic [CH-1:0]       blink_o,
    output logic [CH-1:0]       blink_wrap_o
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_half;
    logic [DIV_W-1:0] div_shadow;
    logic             div_pend;
    logic             div_term;
    logic             div_apply;
    logic             blink_sync;

`ifdef BLINK_SYNC_EN
    assign blink_sync = blink_sync_i;
`else
    assign blink_sync = 1'b0;
`endif

    // New half-period only takes over on the high->low toggle, so every period opens with a full new low phase.
    always_comb begin
        div_term  = (div_cnt == div_half - DIV_W'(1));
        div_apply = div_term && usr_clk_o && div_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            div_half     <= DIV_W'(DIV_DEFAULT);
            div_shadow   <= DIV_W'(DIV_DEFAULT);
            div_pend     <= 1'b0;
            usr_clk_o    <= 1'b0;
            usr_clk_en_o <= 1'b0;
        end else begin
            usr_clk_en_o <= div_term && !usr_clk_o;
            if (div_term) begin
                div_cnt   <= '0;
                usr_clk_o <= !usr_clk_o;
            end else begin
                div_cnt   <= div_cnt + DIV_W'(1);
            end
            if (div_apply) begin
                div_half <= div_shadow;
            end
            if (div_load_i) begin
                div_shadow <= (div_half_i == '0) ? DIV_W'(1) : div_half_i;
                div_pend   <= 1'b1;
            end else if (div_apply) begin
                div_pend   <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        blink_channel #(
            .PERIOD_RST (PERIOD_DEFAULT),
            .DUTY_RST   (DUTY_DEFAULT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .period_i (blink_period_i[k*PER_W +: PER_W]),
            .duty_i   (blink_duty_i[k*PER_W +: PER_W]),
            .load_i   (blink_load_i[k]),
            .sync_i   (blink_sync),
            .blink_o  (blink_o[k]),
            .wrap_o   (blink_wrap_o[k])
        );
    end

endmodule

// File: tb/tb_board_clkgen_blink.sv
// tb/tb_board_clkgen_blink.sv - directed-vector bench for board_clkgen_blink
module tb_board_clkgen_blink;

    localparam int CH    = 4;
    localparam int PER_W = 26;
    localparam int DIV_W = 8;

    logic                clk;
    logic                rst;
    logic [DIV_W-1:0]    div_half_i;
    logic                div_load_i;
    logic                usr_clk_o;
    logic                usr_clk_en_o;
    logic [CH*PER_W-1:0] blink_period_i;
    logic [CH*PER_W-1:0] blink_duty_i;
    logic [CH-1:0]       blink_load_i;
    logic                blink_sync_i;
    logic [CH-1:0]       blink_o;
    logic [CH-1:0]       blink_wrap_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic          usr_tr   [0:255];
    logic          en_tr    [0:255];
    logic [CH-1:0] blink_tr [0:255];
    logic [CH-1:0] wrap_tr  [0:255];

    board_clkgen_blink #(
        .PERIOD_DEFAULT (20),
        .DUTY_DEFAULT   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .div_half_i     (div_half_i),
        .div_load_i     (div_load_i),
        .usr_clk_o      (usr_clk_o),
        .usr_clk_en_o   (usr_clk_en_o),
        .blink_period_i (blink_period_i),
        .blink_duty_i   (blink_duty_i),
        .blink_load_i   (blink_load_i),
`ifdef BLINK_SYNC_EN
        .blink_sync_i   (blink_sync_i),
`endif
        .blink_o        (blink_o),
        .blink_wrap_o   (blink_wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc < 256) begin
            usr_tr[cyc]   = usr_clk_o;
            en_tr[cyc]    = usr_clk_en_o;
            blink_tr[cyc] = blink_o;
            wrap_tr[cyc]  = blink_wrap_o;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    function automatic int count_blink(input int ch, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (blink_tr[c][ch]) n++;
        return n;
    endfunction

    function automatic int count_wrap(input int ch, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (wrap_tr[c][ch]) n++;
        return n;
    endfunction

    function automatic int count_en(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (en_tr[c]) n++;
        return n;
    endfunction

    function automatic int count_toggles(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (usr_tr[c] != usr_tr[c-1]) n++;
        return n;
    endfunction

    initial begin
        rst            = 1'b1;
        div_half_i     = '0;
        div_load_i     = 1'b0;
        blink_period_i = '0;
        blink_duty_i   = '0;
        blink_load_i   = '0;
        blink_sync_i   = 1'b0;

        repeat (3) tick();
        chk("rst_usr_clk", 32'(usr_clk_o), 0);
        chk("rst_usr_en", 32'(usr_clk_en_o), 0);
        chk("rst_blink", 32'(blink_o), 0);
        chk("rst_wrap", 32'(blink_wrap_o), 0);

        rst = 1'b0;
        cyc = 0;

        // Channels: 0 -> 10/3, 1 -> 10/0, 2 -> 10/12, 3 -> disabled; applied at the default wrap (cycle 20)
        run_to(2);
        blink_period_i = {26'd0, 26'd10, 26'd10, 26'd10};
        blink_duty_i   = {26'd5, 26'd12, 26'd0, 26'd3};
        blink_load_i   = 4'hF;
        tick();
        blink_load_i   = '0;

        // Divider reload while usr_clk_o is high (high phase spans 35..39)
        run_to(36);
        div_half_i = 8'd2;
        div_load_i = 1'b1;
        tick();
        div_load_i = 1'b0;

        // Channel 0 reload captured exactly on its wrap edge (cnt=9 at cycle 99)
        run_to(99);
        blink_period_i[25:0] = 26'd6;
        blink_duty_i[25:0]   = 26'd6;
        blink_load_i         = 4'b0001;
        tick();
        blink_load_i         = '0;

        run_to(143);
        rst = 1'b1;
        tick();
        chk("midrst_usr_clk", 32'(usr_clk_o), 0);
        chk("midrst_usr_en", 32'(usr_clk_en_o), 0);
        chk("midrst_blink", 32'(blink_o), 0);
        chk("midrst_wrap", 32'(blink_wrap_o), 0);

        // Divider defaults: half=5
        chk("div_low_c4", 32'(usr_tr[4]), 0);
        chk("div_rise_c5", 32'(usr_tr[5]), 1);
        chk("div_en_c5", 32'(en_tr[5]), 1);
        chk("div_en_c6", 32'(en_tr[6]), 0);
        chk("div_high_c9", 32'(usr_tr[9]), 1);
        chk("div_fall_c10", 32'(usr_tr[10]), 0);
        chk("div_en_count", 32'(count_en(1, 35)), 4);

        // Divider reload to half=2
        chk("div2_old_high_c39", 32'(usr_tr[39]), 1);
        chk("div2_low_c40", 32'(usr_tr[40]), 0);
        chk("div2_low_c41", 32'(usr_tr[41]), 0);
        chk("div2_rise_c42", 32'(usr_tr[42]), 1);
        chk("div2_en_c42", 32'(en_tr[42]), 1);
        chk("div2_en_c44", 32'(en_tr[44]), 0);
        chk("div2_en_c46", 32'(en_tr[46]), 1);
        chk("div2_toggles", 32'(count_toggles(41, 99)), 29);

        // Default blink 20/8 before the apply
        chk("ch0_def_c7", 32'(blink_tr[7][0]), 1);
        chk("ch0_def_c8", 32'(blink_tr[8][0]), 0);
        chk("ch0_def_wrap_c19", 32'(wrap_tr[19][0]), 0);
        chk("all_def_wrap_c20", 32'(wrap_tr[20]), 4'hF);

        // Channel 0: 10/3
        chk("ch0_c22", 32'(blink_tr[22][0]), 1);
        chk("ch0_c23", 32'(blink_tr[23][0]), 0);
        chk("ch0_c30", 32'(blink_tr[30][0]), 1);
        chk("ch0_high_count", 32'(count_blink(0, 20, 99)), 24);
        chk("ch0_wrap_count", 32'(count_wrap(0, 20, 99)), 8);
        chk("ch0_wrap_c29", 32'(wrap_tr[29][0]), 0);

        // Channels 1-3
        chk("ch1_high_count", 32'(count_blink(1, 20, 99)), 0);
        chk("ch1_wrap_c30", 32'(wrap_tr[30][1]), 1);
        chk("ch2_high_count", 32'(count_blink(2, 20, 99)), 80);
        chk("ch3_high_count", 32'(count_blink(3, 20, 143)), 0);
        chk("ch3_wrap_count", 32'(count_wrap(3, 21, 143)), 0);

        // Channel 0 reload in wrap cycle: one more 10/3 period, then 6/6
        chk("ch0_rl_wrap_c100", 32'(wrap_tr[100][0]), 1);
        chk("ch0_rl_c103", 32'(blink_tr[103][0]), 0);
        chk("ch0_rl_wrap_c106", 32'(wrap_tr[106][0]), 0);
        chk("ch0_rl_wrap_c110", 32'(wrap_tr[110][0]), 1);
        chk("ch0_rl_wrap_c116", 32'(wrap_tr[116][0]), 1);
        chk("ch0_rl_high_count", 32'(count_blink(0, 110, 143)), 34);

        // Defaults restored after mid-run reset
        rst = 1'b0;
        cyc = 0;
`ifdef BLINK_SYNC_EN
        run_to(5);
        blink_sync_i = 1'b1;
        tick();
        blink_sync_i = 1'b0;
`endif
        run_to(30);
        chk("post_low_c4", 32'(usr_tr[4]), 0);
        chk("post_rise_c5", 32'(usr_tr[5]), 1);
        chk("post_en_c5", 32'(en_tr[5]), 1);
        chk("post_fall_c10", 32'(usr_tr[10]), 0);
        chk("post_wrap_c10", 32'(wrap_tr[10]), 0);
`ifdef BLINK_SYNC_EN
        chk("sync_wrap_c6", 32'(wrap_tr[6]), 0);
        chk("sync_wrap_c20", 32'(wrap_tr[20]), 0);
        chk("sync_wrap_c26", 32'(wrap_tr[26]), 4'hF);
        chk("sync_blink_c13", 32'(blink_tr[13]), 4'hF);
        chk("sync_blink_c14", 32'(blink_tr[14]), 0);
`else
        chk("post_wrap_c20", 32'(wrap_tr[20]), 4'hF);
        chk("post_blink_c7", 32'(blink_tr[7]), 4'hF);
        chk("post_blink_c8", 32'(blink_tr[8]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
